register_file_writeback: RTL and testbench
==========================================

Name: register_file_writeback

Overview:
- Writer-side front end for the CPU register file's single write port.
- Merges single-cycle ALU results with buffered long-latency results (mul/div/load) into one registered write stream for the register file.
- Tracks which registers have outstanding long-latency writes so decode can stall on them.
- Sits between execute/memory stages and the register file write port.

Parameters:
DATA_WIDTH, 32, register data width
NUM_REGS, 16, number of architectural registers; sel width = log2(NUM_REGS) = 4
LONG_FIFO_DEPTH, 2, entries in the long-result buffer (power of 2, >= 2)
STARVE_LIMIT, 4, consecutive ALU wins over a non-empty FIFO before the FIFO is forced

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_alu_valid  in  1  ALU result present
in_alu_sel  in  4  ALU destination register
in_alu_data  in  32  ALU result
out_alu_ready  out  1  ALU result accepted this cycle
in_long_valid  in  1  long-latency result present
in_long_sel  in  4  long-latency destination register
in_long_data  in  32  long-latency result
out_long_ready  out  1  FIFO can accept a long-latency result
in_claim_valid  in  1  decode issued a long-latency op
in_claim_sel  in  4  destination of the issued op
out_busy_mask  out  16  bit i = register i has a pending long write
out_write_en  out  1  register file write enable
out_write_sel  out  4  register file write select
out_write_data  out  32  register file write data
out_fifo_count  out  2  FIFO occupancy (0..LONG_FIFO_DEPTH)

Behaviour:
- Reset (rst=1 at posedge) clears:
  - out_write_en, out_write_sel, out_write_data, out_busy_mask, out_fifo_count, FIFO pointers and starve counter → all 0.
  - Reset mid-operation discards buffered entries and pending claims.
- out_long_ready = (count < LONG_FIFO_DEPTH). It is a function of registered count only; a same-cycle pop does not raise it.
- Long accept = in_long_valid && out_long_ready.
  - sel != 0: push.
  - sel == 0: accepted and dropped; nothing pushed and no busy change.
- force_long = FIFO non-empty && starve_cnt == STARVE_LIMIT.
- out_alu_ready = !force_long (combinational). An ALU result is taken when in_alu_valid && out_alu_ready.
- Arbitration each cycle (decided combinationally, committed at posedge):
  1. ALU taken: out_write_en <= (in_alu_sel != 0), sel/data <= ALU. No pop.
  2. Else if FIFO non-empty: pop head; out_write_en <= 1, sel/data <= head.
  3. Else: out_write_en <= 0; sel/data hold previous values.
  - An ALU result to r0 is consumed with write_en=0 and still counts as an ALU win.
- Write latency: one cycle from input to out_write_*; out_write_en is high for exactly one cycle per write.
- Starve counter:
  - Increments when an ALU result wins while the FIFO is non-empty (saturates at STARVE_LIMIT).
  - Clears on any pop or when the FIFO is empty.
- FIFO:
  - Circular buffer; pointers wrap modulo LONG_FIFO_DEPTH.
  - Simultaneous push and pop: count unchanged. This cannot occur at full because ready is low.
  - Strict FIFO order.
- Busy mask:
  - Set bit in_claim_sel on in_claim_valid (sel != 0).
  - Clear bit head.sel at the posedge where that entry is popped.
  - Same register set and cleared in one cycle: set wins.
  - A claim to r0 is ignored; bit 0 is always 0.
- No same-register ordering check between ALU and FIFO. Decode guarantees no ALU write to a busy register.
- out_fifo_count = registered count.

Test Plan:
- Reset then idle: out_write_en=0, out_busy_mask=0x0000, out_long_ready=1, out_fifo_count=0.
- ALU-only: in_alu_valid=1, sel=3, data=0xDEADBEEF at cycle N → out_write_en=1, sel=3, data=0xDEADBEEF at N+1; sel=0 → out_write_en=0 and out_alu_ready=1.
- Claim r5, then long result (sel=5, data=0x12345678) with ALU idle:
  - out_busy_mask=0x0020 after the claim.
  - Push, then pop next cycle; write of r5=0x12345678 appears.
  - Busy bit 5 clears on the same edge as out_write_en rises.
- Fill FIFO with long writes to r1 and r2 while ALU valid every cycle (STARVE_LIMIT=4):
  - out_long_ready=0 at count=2.
  - After 4 ALU wins, out_alu_ready=0 for one cycle and r1 is written.
  - After 4 more ALU wins, r2 is written.
  - Order is r1 then r2.
- Simultaneous claim of r7 and pop of an entry for r7 in the same cycle → bit 7 remains 1.
- rst asserted with count=2 and busy=0x0006 → next cycle count=0, busy=0, out_write_en=0; earlier buffered data is never written.

Source files
------------

// File: rtl/register_file_writeback.sv
// Write-port front end for the register file: arbitrates single-cycle ALU results
// against buffered long-latency results and tracks registers with pending long writes.
module register_file_writeback #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NUM_REGS        = 16,
    parameter int unsigned LONG_FIFO_DEPTH = 2,
    parameter int unsigned STARVE_LIMIT    = 4,
    localparam int unsigned SEL_W = $clog2(NUM_REGS),
    localparam int unsigned CNT_W = $clog2(LONG_FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_alu_valid,
    input  logic [SEL_W-1:0]      in_alu_sel,
    input  logic [DATA_WIDTH-1:0] in_alu_data,
    output logic                  out_alu_ready,
    input  logic                  in_long_valid,
    input  logic [SEL_W-1:0]      in_long_sel,
    input  logic [DATA_WIDTH-1:0] in_long_data,
    output logic                  out_long_ready,
    input  logic                  in_claim_valid,
    input  logic [SEL_W-1:0]      in_claim_sel,
    output logic [NUM_REGS-1:0]   out_busy_mask,
    output logic                  out_write_en,
    output logic [SEL_W-1:0]      out_write_sel,
    output logic [DATA_WIDTH-1:0] out_write_data,
    output logic [CNT_W-1:0]      out_fifo_count
);

    localparam int unsigned PTR_W = (LONG_FIFO_DEPTH > 1) ? $clog2(LONG_FIFO_DEPTH) : 1;
    localparam int unsigned ST_W  = $clog2(STARVE_LIMIT + 1);

    logic [SEL_W-1:0]      fifo_sel  [LONG_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [LONG_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [ST_W-1:0]       starve_cnt;
    logic [NUM_REGS-1:0]   busy, busy_next;

    logic fifo_empty, force_long, alu_take, push, pop;

    always_comb begin
        fifo_empty     = (count == '0);
        out_long_ready = (count < CNT_W'(LONG_FIFO_DEPTH));
        force_long     = !fifo_empty && (starve_cnt == ST_W'(STARVE_LIMIT));
        out_alu_ready  = !force_long;
        alu_take       = in_alu_valid && out_alu_ready;
        pop            = !alu_take && !fifo_empty;
        // r0 long results are accepted (ready handshake) but never buffered
        push           = in_long_valid && out_long_ready && (in_long_sel != '0);
    end

    // Pop clears first so a same-cycle claim of the popped register keeps it busy
    always_comb begin
        busy_next = busy;
        if (pop)
            busy_next[fifo_sel[rd_ptr]] = 1'b0;
        if (in_claim_valid && (in_claim_sel != '0))
            busy_next[in_claim_sel] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            starve_cnt     <= '0;
            busy           <= '0;
            out_write_en   <= 1'b0;
            out_write_sel  <= '0;
            out_write_data <= '0;
        end else begin
            busy <= busy_next;

            if (push) begin
                fifo_sel[wr_ptr]  <= in_long_sel;
                fifo_data[wr_ptr] <= in_long_data;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);

            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);

            if (pop || fifo_empty)
                starve_cnt <= '0;
            else if (alu_take && (starve_cnt != ST_W'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + ST_W'(1);

            if (alu_take) begin
                out_write_en   <= (in_alu_sel != '0);
                out_write_sel  <= in_alu_sel;
                out_write_data <= in_alu_data;
            end else if (pop) begin
                out_write_en   <= 1'b1;
                out_write_sel  <= fifo_sel[rd_ptr];
                out_write_data <= fifo_data[rd_ptr];
            end else begin
                out_write_en   <= 1'b0;
            end
        end
    end

    assign out_busy_mask  = busy;
    assign out_fifo_count = count;

endmodule

// File: tb/tb_register_file_writeback.sv
// Directed bench for register_file_writeback: expected register-file writes are queued
// by the stimulus and consumed by an independent write-port monitor.
module tb_register_file_writeback;

    logic        clk;
    logic        rst;
    logic        in_alu_valid;
    logic [3:0]  in_alu_sel;
    logic [31:0] in_alu_data;
    logic        out_alu_ready;
    logic        in_long_valid;
    logic [3:0]  in_long_sel;
    logic [31:0] in_long_data;
    logic        out_long_ready;
    logic        in_claim_valid;
    logic [3:0]  in_claim_sel;
    logic [15:0] out_busy_mask;
    logic        out_write_en;
    logic [3:0]  out_write_sel;
    logic [31:0] out_write_data;
    logic [1:0]  out_fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [35:0] exp_q[$];

    register_file_writeback #(
        .DATA_WIDTH(32),
        .NUM_REGS(16),
        .LONG_FIFO_DEPTH(2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_alu_valid(in_alu_valid),
        .in_alu_sel(in_alu_sel),
        .in_alu_data(in_alu_data),
        .out_alu_ready(out_alu_ready),
        .in_long_valid(in_long_valid),
        .in_long_sel(in_long_sel),
        .in_long_data(in_long_data),
        .out_long_ready(out_long_ready),
        .in_claim_valid(in_claim_valid),
        .in_claim_sel(in_claim_sel),
        .out_busy_mask(out_busy_mask),
        .out_write_en(out_write_en),
        .out_write_sel(out_write_sel),
        .out_write_data(out_write_data),
        .out_fifo_count(out_fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_alu_valid   = 1'b0;
        in_alu_sel     = '0;
        in_alu_data    = '0;
        in_long_valid  = 1'b0;
        in_long_sel    = '0;
        in_long_data   = '0;
        in_claim_valid = 1'b0;
        in_claim_sel   = '0;
    endtask

    // Every write seen on the port must match the oldest expected write
    always @(negedge clk) begin
        if (out_write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {28'd0, out_write_sel, out_write_data}, 64'd0);
            end else begin
                check("write_sel_data", {28'd0, out_write_sel, out_write_data},
                      {28'd0, exp_q.pop_front()});
            end
        end
    end

    logic [31:0] alu_d;

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // reset / idle
        check("rst_write_en", out_write_en, 0);
        check("rst_busy", out_busy_mask, 16'h0000);
        check("rst_long_ready", out_long_ready, 1);
        check("rst_count", out_fifo_count, 0);
        check("rst_alu_ready", out_alu_ready, 1);

        // ALU-only writes, including r0
        in_alu_valid = 1'b1; in_alu_sel = 4'd3; in_alu_data = 32'hDEADBEEF;
        exp_q.push_back({4'd3, 32'hDEADBEEF});
        tick();
        check("alu_write_en", out_write_en, 1);
        in_alu_sel = 4'd0; in_alu_data = 32'h11111111;
        check("alu_r0_ready", out_alu_ready, 1);
        tick();
        check("alu_r0_write_en", out_write_en, 0);
        idle_inputs();
        tick();

        // claim r5, then long result with ALU idle
        in_claim_valid = 1'b1; in_claim_sel = 4'd5;
        tick();
        idle_inputs();
        check("claim_r5_busy", out_busy_mask, 16'h0020);
        in_long_valid = 1'b1; in_long_sel = 4'd5; in_long_data = 32'h12345678;
        check("long_ready_empty", out_long_ready, 1);
        exp_q.push_back({4'd5, 32'h12345678});
        tick();
        idle_inputs();
        check("long_push_count", out_fifo_count, 1);
        check("long_push_busy", out_busy_mask, 16'h0020);
        tick();
        check("long_pop_write_en", out_write_en, 1);
        check("long_pop_busy_clear", out_busy_mask, 16'h0000);
        check("long_pop_count", out_fifo_count, 0);

        // starvation: ALU valid every cycle while r1, r2 sit in the FIFO
        alu_d = 32'hA0000000;
        for (int c = 0; c < 12; c++) begin
            in_alu_valid   = 1'b1; in_alu_sel = 4'd8; in_alu_data = alu_d;
            in_long_valid  = (c < 2);
            in_long_sel    = (c == 0) ? 4'd1 : 4'd2;
            in_long_data   = (c == 0) ? 32'h0000_1111 : 32'h0000_2222;
            in_claim_valid = (c < 2);
            in_claim_sel   = (c == 0) ? 4'd1 : 4'd2;
            check($sformatf("starve_alu_ready_c%0d", c), out_alu_ready, !(c == 5 || c == 10));
            if (c == 2) begin
                check("full_long_ready", out_long_ready, 0);
                check("full_count", out_fifo_count, 2);
            end
            if (c == 5)       exp_q.push_back({4'd1, 32'h0000_1111});
            else if (c == 10) exp_q.push_back({4'd2, 32'h0000_2222});
            else begin
                exp_q.push_back({4'd8, alu_d});
                alu_d = alu_d + 1;
            end
            tick();
            if (c == 1)  check("starve_busy_c1", out_busy_mask, 16'h0006);
            if (c == 5)  check("starve_busy_c5", out_busy_mask, 16'h0004);
            if (c == 10) check("starve_busy_c10", out_busy_mask, 16'h0000);
        end
        idle_inputs();
        tick();
        check("starve_drained", out_fifo_count, 0);

        // reset mid-operation with two buffered entries
        in_alu_valid = 1'b1; in_alu_sel = 4'd0; in_alu_data = 32'h5;
        in_claim_valid = 1'b1; in_claim_sel = 4'd1;
        in_long_valid = 1'b1; in_long_sel = 4'd1; in_long_data = 32'hBAD00001;
        tick();
        in_claim_sel = 4'd2; in_long_sel = 4'd2; in_long_data = 32'hBAD00002;
        tick();
        check("prerst_count", out_fifo_count, 2);
        check("prerst_busy", out_busy_mask, 16'h0006);
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_count", out_fifo_count, 0);
        check("midrst_busy", out_busy_mask, 16'h0000);
        check("midrst_write_en", out_write_en, 0);
        check("midrst_long_ready", out_long_ready, 1);
        repeat (5) tick();
        check("midrst_still_empty", out_fifo_count, 0);

        // claim and pop of r7 on the same edge: set wins
        in_long_valid = 1'b1; in_long_sel = 4'd7; in_long_data = 32'h77777777;
        in_claim_valid = 1'b1; in_claim_sel = 4'd7;
        exp_q.push_back({4'd7, 32'h77777777});
        tick();
        in_long_valid = 1'b0;
        tick();
        idle_inputs();
        check("r7_pop_write_en", out_write_en, 1);
        check("r7_busy_kept", out_busy_mask, 16'h0080);

        // r0 long result dropped, r0 claim ignored
        in_long_valid = 1'b1; in_long_sel = 4'd0; in_long_data = 32'hCAFE0000;
        in_claim_valid = 1'b1; in_claim_sel = 4'd0;
        check("r0_long_ready", out_long_ready, 1);
        tick();
        idle_inputs();
        check("r0_long_count", out_fifo_count, 0);
        check("r0_claim_busy", out_busy_mask, 16'h0080);
        repeat (3) tick();

        check("pending_writes", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
